// File: rtl/avalon_board_io.sv
// Avalon-MM board I/O slave: synchronised, debounced switches/keys, LED register with set/clear aliases, key-press edge capture and level IRQ.
// Latency: pin to debounced state 2+DEBOUNCE_CYC cycles; readdata 1 cycle after read; irq 1 cycle after edge/mask change.
// Backpressure: none, no waitrequest, every access completes in one cycle. Optional switch-edge capture via BOARD_IO_SW_EDGE_EN.
module avalon_board_io #(
    parameter int SW_W         = 8,
    parameter int KEY_W        = 2,
    parameter int LED_W        = 8,
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [SW_W-1:0]  sw_in,
    input  logic [KEY_W-1:0] key_n_in,
    output logic [LED_W-1:0] led_out,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq
);
    localparam int IN_W  = SW_W + KEY_W;
    localparam int CNT_W = $clog2(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [31:0] MASK_BITS = (KEY_W >= 32) ? 32'hFFFF_FFFF
                                      : (((32'd1 << KEY_W) - 32'd1) | 32'h8000_0000);

    logic [IN_W-1:0]  meta_q, sync_q, in_lvl, deb_q, flip;
    logic [KEY_W-1:0] key_rise, key_edge_q, w1c_key;
    logic [31:0]      key_mask_q, rd_mux, sw_rd;
    logic             wr_en, rd_en, sw_irq;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= {key_n_in, sw_in};
            sync_q <= meta_q;
        end
    end

    // Keys are active-low on the board; everything downstream sees 1 = pressed.
    assign in_lvl = {~sync_q[IN_W-1:SW_W], sync_q[SW_W-1:0]};

    for (genvar i = 0; i < IN_W; i++) begin : g_deb
        logic [CNT_W-1:0] cnt_q;
        assign flip[i] = (in_lvl[i] != deb_q[i]) && (cnt_q == CNT_LAST);
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)                                 cnt_q <= '0;
            else if ((in_lvl[i] == deb_q[i]) || flip[i])  cnt_q <= '0;
            else                                          cnt_q <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) deb_q <= '0;
        else          deb_q <= deb_q ^ flip;
    end

    assign key_rise = flip[IN_W-1:SW_W] & ~deb_q[IN_W-1:SW_W];
    assign wr_en    = chipselect & write;
    assign rd_en    = chipselect & read;
    assign w1c_key  = (wr_en && address == 3'd5) ? writedata[KEY_W-1:0] : '0;

`ifdef BOARD_IO_SW_EDGE_EN
    logic [SW_W-1:0] sw_edge_q, w1c_sw;
    assign w1c_sw = (wr_en && address == 3'd7) ? writedata[SW_W-1:0] : '0;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sw_edge_q <= '0;
        else          sw_edge_q <= (sw_edge_q & ~w1c_sw) | flip[SW_W-1:0];
    end
    assign sw_irq = (|sw_edge_q) & key_mask_q[31];
    assign sw_rd  = 32'(sw_edge_q);
`else
    assign sw_irq = 1'b0;
    assign sw_rd  = '0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_out    <= '0;
            key_mask_q <= '0;
            key_edge_q <= '0;
        end else begin
            if (wr_en) begin
                case (address)
                    3'd2:    led_out    <= writedata[LED_W-1:0];
                    3'd3:    led_out    <= led_out | writedata[LED_W-1:0];
                    3'd4:    led_out    <= led_out & ~writedata[LED_W-1:0];
                    3'd6:    key_mask_q <= writedata & MASK_BITS;
                    default: ;
                endcase
            end
            // A press landing in the same cycle as its clear must not be lost.
            key_edge_q <= (key_edge_q & ~w1c_key) | key_rise;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            3'd0:    rd_mux = 32'(deb_q[SW_W-1:0]);
            3'd1:    rd_mux = 32'(deb_q[IN_W-1:SW_W]);
            3'd2:    rd_mux = 32'(led_out);
            3'd5:    rd_mux = 32'(key_edge_q);
            3'd6:    rd_mux = key_mask_q;
            3'd7:    rd_mux = sw_rd;
            default: rd_mux = '0;
        endcase
    end

    // Registers are sampled before any same-cycle write lands, so read+write returns the old value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            if (rd_en) readdata <= rd_mux;
            irq <= (|(key_edge_q & key_mask_q[KEY_W-1:0])) | sw_irq;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{writedata, key_mask_q};
endmodule

// File: tb/tb_avalon_board_io.sv
// Scoreboard bench for avalon_board_io: directed board scenarios then random bus/pin traffic against a window-based reference model.
module tb_avalon_board_io;
    localparam int DC = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  sw_in;
    logic [1:0]  key_n_in;
    logic [7:0]  led_out;
    logic [2:0]  address;
    logic        chipselect, read, write;
    logic [31:0] writedata, readdata;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    avalon_board_io #(.SW_W(8), .KEY_W(2), .LED_W(8), .DEBOUNCE_CYC(DC)) dut (
        .clk(clk), .reset_n(reset_n), .sw_in(sw_in), .key_n_in(key_n_in), .led_out(led_out),
        .address(address), .chipselect(chipselect), .read(read), .write(write),
        .writedata(writedata), .readdata(readdata), .irq(irq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: a bit's debounced level follows its synchronised level once the
    // last DC synchronised samples since reset all disagree with the current debounced level.
    logic [9:0]  p1, p2, deb_m;
    logic [9:0]  hist [DC];
    logic [1:0]  kedge_m;
    logic [7:0]  sedge_m, led_m;
    logic [31:0] mask_m, hold_m;
    logic        irq_m;
    int          since;
    logic [31:0] exp_q [$];

    function automatic logic [31:0] reg_val(input logic [2:0] a);
        case (a)
            3'd0: return {24'd0, deb_m[7:0]};
            3'd1: return {30'd0, deb_m[9:8]};
            3'd2: return {24'd0, led_m};
            3'd5: return {30'd0, kedge_m};
            3'd6: return mask_m;
`ifdef BOARD_IO_SW_EDGE_EN
            3'd7: return {24'd0, sedge_m};
`endif
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin : model
        logic [9:0]  s, flp, nd;
        logic [9:0]  win [DC];
        logic [1:0]  w1k;
        logic [7:0]  w1s, nled;
        logic        wr, rd, nirq;
        if (!reset_n) begin
            p1 <= '0; p2 <= '0; deb_m <= '0; kedge_m <= '0; sedge_m <= '0;
            led_m <= '0; mask_m <= '0; hold_m <= '0; irq_m <= 1'b0; since <= 0;
            for (int k = 0; k < DC; k++) hist[k] <= '0;
        end else begin
            s = {~p2[9:8], p2[7:0]};
            win[0] = s;
            for (int k = 1; k < DC; k++) win[k] = hist[k-1];
            flp = '0;
            if (since + 1 >= DC) begin
                for (int b = 0; b < 10; b++) begin
                    flp[b] = 1'b1;
                    for (int k = 0; k < DC; k++) if (win[k][b] == deb_m[b]) flp[b] = 1'b0;
                end
            end
            nd = deb_m ^ flp;
            wr = chipselect & write;
            rd = chipselect & read;
            if (rd) begin
                exp_q.push_back(reg_val(address));
                hold_m <= reg_val(address);
            end
            nirq = |(kedge_m & mask_m[1:0]);
`ifdef BOARD_IO_SW_EDGE_EN
            nirq = nirq | ((|sedge_m) & mask_m[31]);
`endif
            w1k = (wr && address == 3'd5) ? writedata[1:0] : 2'b00;
            w1s = (wr && address == 3'd7) ? writedata[7:0] : 8'h00;
            nled = led_m;
            if (wr && address == 3'd2) nled = writedata[7:0];
            if (wr && address == 3'd3) nled = led_m | writedata[7:0];
            if (wr && address == 3'd4) nled = led_m & ~writedata[7:0];
            if (wr && address == 3'd6) mask_m <= writedata & 32'h8000_0003;
            led_m   <= nled;
            kedge_m <= (kedge_m & ~w1k) | (nd[9:8] & ~deb_m[9:8]);
            sedge_m <= (sedge_m & ~w1s) | flp[7:0];
            deb_m   <= nd;
            irq_m   <= nirq;
            for (int k = 0; k < DC; k++) hist[k] <= win[k];
            if (since < DC) since <= since + 1;
            p2 <= p1;
            p1 <= {key_n_in, sw_in};
        end
    end

    // Monitor: readdata is compared against the queued response when a read completed,
    // otherwise it must still hold the last read value.
    always @(negedge clk) begin
        #1;
        chk("led_out", {24'd0, led_out}, {24'd0, led_m});
        chk("irq", {31'd0, irq}, {31'd0, irq_m});
        if (exp_q.size() > 0) chk("readdata", readdata, exp_q.pop_front());
        else                  chk("readdata_hold", readdata, hold_m);
    end

    task automatic bus_op(input logic cs, input logic rd, input logic wr, input logic [2:0] a,
                          input logic [31:0] wd, output logic [31:0] d);
        @(negedge clk);
        chipselect = cs; read = rd; write = wr; address = a; writedata = wd;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0; write = 1'b0;
        d = readdata;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        bus_op(1'b1, 1'b1, 1'b0, a, 32'd0, d);
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] wd);
        logic [31:0] d;
        bus_op(1'b1, 1'b0, 1'b1, a, wd, d);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        reset_n = 1'b0; sw_in = 8'hA5; key_n_in = 2'b11;
        address = '0; chipselect = 1'b0; read = 1'b0; write = 1'b0; writedata = '0;
        repeat (3) @(negedge clk);
        chk("reset led_out", {24'd0, led_out}, 32'd0);
        chk("reset irq", {31'd0, irq}, 32'd0);
        chk("reset readdata", readdata, 32'd0);
        reset_n = 1'b1;
        idle(8);
        bus_read(3'd0, d); chk("sw_data after reset", d, 32'h0000_00A5);
        bus_read(3'd1, d); chk("key_data after reset", d, 32'd0);

        // 3-cycle glitch must be rejected, 6-cycle hold accepted
        @(negedge clk); key_n_in[0] = 1'b0;
        idle(3); key_n_in[0] = 1'b1;
        idle(8);
        bus_read(3'd1, d); chk("key glitch data", d, 32'd0);
        bus_read(3'd5, d); chk("key glitch edge", d, 32'd0);
        @(negedge clk); key_n_in[0] = 1'b0;
        idle(6);
        bus_read(3'd1, d); chk("key held data", d, 32'd1);
        bus_read(3'd5, d); chk("key held edge", d, 32'd1);

        // IRQ timing and W1C
        bus_write(3'd5, 32'd1);
        @(negedge clk); key_n_in[0] = 1'b1;
        idle(8);
        bus_write(3'd6, 32'd1);
        bus_read(3'd5, d); chk("edge after release", d, 32'd0);
        @(negedge clk); key_n_in[0] = 1'b0;
        idle(5); chk("irq before edge", {31'd0, irq}, 32'd0);
        idle(1); chk("irq at edge cycle", {31'd0, irq}, 32'd0);
        idle(1); chk("irq after edge", {31'd0, irq}, 32'd1);
        bus_write(3'd5, 32'd1);
        idle(1); chk("irq after w1c", {31'd0, irq}, 32'd0);
        @(negedge clk); key_n_in[0] = 1'b1;
        idle(8);
        bus_read(3'd5, d); chk("release sets no edge", d, 32'd0);

        // LED aliases
        bus_write(3'd2, 32'h0F);
        bus_write(3'd3, 32'hF0);
        bus_write(3'd4, 32'h3C);
        chk("led aliases", {24'd0, led_out}, 32'h0000_00C3);
        bus_read(3'd3, d); chk("led_set reads 0", d, 32'd0);
        bus_read(3'd2, d); chk("led_data readback", d, 32'h0000_00C3);
        bus_write(3'd2, 32'hFFFF_FF00);
        chk("led high bits ignored", {24'd0, led_out}, 32'd0);
        bus_write(3'd6, 32'hFFFF_FFFF);
        bus_read(3'd6, d); chk("key_mask stored bits", d, 32'h8000_0003);
        bus_write(3'd6, 32'd1);

        // W1C collides with key1 rising edge: set wins
        @(negedge clk); key_n_in[1] = 1'b0;
        idle(4);
        bus_write(3'd5, 32'd2);
        bus_read(3'd5, d); chk("edge set wins", d, 32'd2);
        @(negedge clk); key_n_in[1] = 1'b1;
        idle(8);
        bus_write(3'd5, 32'd3);

        // Reset in the middle of a debounce
        @(negedge clk); sw_in[0] = 1'b0;
        idle(3); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        bus_read(3'd0, d); chk("sw_data after mid reset", d, 32'd0);
        bus_read(3'd1, d); chk("key_data after mid reset", d, 32'd0);
        idle(8);
        bus_read(3'd0, d); chk("sw_data re-debounced", d, 32'h0000_00A4);

`ifdef BOARD_IO_SW_EDGE_EN
        bus_write(3'd7, 32'hFF);
        @(negedge clk); sw_in[3] = 1'b1;
        idle(8);
        bus_read(3'd7, d); chk("sw_edge bit3", d, 32'h0000_0008);
        bus_write(3'd6, 32'h8000_0000);
        idle(1); chk("sw irq", {31'd0, irq}, 32'd1);
        bus_write(3'd7, 32'h08);
        idle(1); chk("sw irq cleared", {31'd0, irq}, 32'd0);
`else
        bus_write(3'd7, 32'hFF);
        @(negedge clk); sw_in[3] = 1'b1;
        idle(8);
        bus_read(3'd7, d); chk("addr7 reads 0", d, 32'd0);
        bus_write(3'd6, 32'h8000_0000);
        idle(1); chk("mask31 no irq", {31'd0, irq}, 32'd0);
`endif

        // Random bus and pin traffic, checked by the monitor
        for (int it = 0; it < 400; it++) begin
            int op;
            int b;
            op = $urandom_range(0, 6);
            case (op)
                0: bus_read(3'($urandom_range(0, 7)), d);
                1: bus_write(3'($urandom_range(0, 7)), $urandom);
                2: bus_op(1'b1, 1'b1, 1'b1, 3'($urandom_range(0, 7)), $urandom, d);
                3: bus_op(1'b0, 1'($urandom_range(0, 1)), 1'b1, 3'($urandom_range(0, 7)), $urandom, d);
                4: begin
                    @(negedge clk);
                    b = $urandom_range(0, 9);
                    if (b < 8) sw_in[b] = ~sw_in[b]; else key_n_in[b-8] = ~key_n_in[b-8];
                end
                5: begin
                    @(negedge clk);
                    b = $urandom_range(0, 9);
                    if (b < 8) sw_in[b] = ~sw_in[b]; else key_n_in[b-8] = ~key_n_in[b-8];
                    idle($urandom_range(1, 5));
                    if (b < 8) sw_in[b] = ~sw_in[b]; else key_n_in[b-8] = ~key_n_in[b-8];
                end
                default: idle($urandom_range(1, 8));
            endcase
        end

        idle(4);
        chk("scoreboard drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
